// File: rtl/maze_pkg.sv
// Shared maze types: move direction encoding and path player state encoding.
// Used by the solver controller, the datapath and the path player.
package maze_pkg;

  localparam int unsigned DIR_W = 2;

  // Move encoding of one path-list entry
  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;  // y-1
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;  // x+1
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;  // x-1
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;  // y+1

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_CHECK,
    PS_STEP,
    PS_OUT,
    PS_HOLD,
    PS_DONE
  } player_state_e;

endpackage

// File: rtl/maze_step_timer.sv
// Loadable down-counter that times the dwell after each accepted move.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (has priority over en)
//   en        - decrement by one, stops at zero
//   load_val  - value loaded on load
//   zero      - counter currently holds zero
module maze_step_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/maze_path_player.sv
// Replays the solved path list as a sequence of (x, y) positions.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   read_checkList    - start request from the controller (level)
//   list_empty        - path list has no entries
//   list_data         - head entry of the path list
//   list_pop          - consume head entry this cycle
//   pos_x, pos_y      - current position
//   move_valid        - new position presented, held until move_ready
//   move_ready        - consumer accepts position
//   move_count        - moves emitted since start (saturating)
//   busy              - playback in progress
//   finished_reading  - one-cycle pulse when the list is drained
module maze_path_player
  import maze_pkg::*;
#(
  parameter int unsigned XW   = 4,
  parameter int unsigned YW   = 4,
  parameter int unsigned HOLD = 4,
  parameter int unsigned CW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_checkList,
  input  logic             list_empty,
  input  logic [DIR_W-1:0] list_data,
  output logic             list_pop,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [CW-1:0]    move_count,
  output logic             busy,
  output logic             finished_reading
);

  // Dwell counter only needs to hold HOLD-1; keep at least one bit
  localparam int unsigned   TW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD - 1);

  player_state_e    state;
  player_state_e    state_nxt;
  logic [DIR_W-1:0] dir;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt        = state;
    list_pop         = 1'b0;
    move_valid       = 1'b0;
    busy             = 1'b1;
    finished_reading = 1'b0;
    tmr_load         = 1'b0;
    tmr_en           = 1'b0;
    case (state)
      PS_IDLE: begin
        busy = 1'b0;
        if (read_checkList) begin
          state_nxt = PS_CHECK;
        end
      end
      PS_CHECK: begin
        if (list_empty) begin
          state_nxt = PS_DONE;
        end else begin
          list_pop  = 1'b1;
          state_nxt = PS_STEP;
        end
      end
      PS_STEP: begin
        state_nxt = PS_OUT;
      end
      PS_OUT: begin
        move_valid = 1'b1;
        if (move_ready) begin
          tmr_load  = 1'b1;
          state_nxt = PS_HOLD;
        end
      end
      PS_HOLD: begin
        // Timer was loaded with HOLD-1, so this state lasts HOLD cycles
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_nxt = PS_CHECK;
        end
      end
      PS_DONE: begin
        finished_reading = 1'b1;
        state_nxt        = PS_IDLE;
      end
      default: begin
        state_nxt = PS_IDLE;
      end
    endcase
  end

  // Position, move counter and latched direction
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x      <= '0;
      pos_y      <= '0;
      move_count <= '0;
      dir        <= DIR_UP;
    end else begin
      case (state)
        PS_IDLE: begin
          if (read_checkList) begin
            pos_x      <= '0;
            pos_y      <= '0;
            move_count <= '0;
          end
        end
        PS_CHECK: begin
          if (!list_empty) begin
            dir <= list_data;
          end
        end
        PS_STEP: begin
          // Coordinates wrap modulo the maze size
          case (dir)
            DIR_UP:    pos_y <= pos_y - YW'(1);
            DIR_RIGHT: pos_x <= pos_x + XW'(1);
            DIR_LEFT:  pos_x <= pos_x - XW'(1);
            default:   pos_y <= pos_y + YW'(1);
          endcase
          if (move_count != '1) begin
            move_count <= move_count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  maze_step_timer #(
    .W (TW)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (HOLD_LOAD),
    .zero     (tmr_zero)
  );

endmodule

// File: doc/maze_path_player.md
# maze_path_player

Downstream stage of the maze solver controller. After the controller reports Done and the user asserts run, the controller holds read_checkList high. This block then drains the solved-path list (2-bit moves, head = first move from the start cell) one entry at a time. For each entry it updates a running (x, y) position and presents it on a valid/ready output port, holding each step for a programmable dwell. When the list is empty it pulses finished_reading back to the controller.

## Interface
Parameters:
- XW, 4, x coordinate width (maze is 2^XW columns)
- YW, 4, y coordinate width (maze is 2^YW rows)
- HOLD, 4, dwell cycles after each accepted move; legal range 1..255
- CW, 8, width of move counter

Ports (one clock, clk; reset rst is synchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- read_checkList  in  1  start request from controller (level)
- list_empty  in  1  path list has no entries
- list_data  in  2  head entry, valid whenever list_empty=0
- list_pop  out  1  consume head entry this cycle
- pos_x  out  XW  current position x
- pos_y  out  YW  current position y
- move_valid  out  1  pos_x/pos_y hold a new position
- move_ready  in  1  consumer accepts position
- move_count  out  CW  moves emitted since start
- busy  out  1  playback in progress
- finished_reading  out  1  one-cycle pulse, list drained

## Operation
- Direction encoding: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- Coordinate arithmetic is modulo 2^XW / 2^YW, so it wraps silently. The solver never produces a wrapping move. Wrap is defined here only so behaviour is total.
- FSM states: IDLE, CHECK, STEP, OUT, HOLD, DONE.
  - IDLE: when read_checkList=1, clear pos_x, pos_y and move_count, then go to CHECK. Otherwise stay in IDLE.
  - CHECK: if list_empty, go to DONE. Otherwise latch list_data into dir, assert list_pop for exactly this cycle, then go to STEP.
  - STEP: apply dir to pos_x/pos_y, increment move_count (saturating at all-ones), then go to OUT.
  - OUT: move_valid=1 with stable pos_x/pos_y. If move_ready, load the dwell counter with HOLD-1 and go to HOLD. Otherwise stay in OUT.
  - HOLD: decrement the dwell counter. When it reaches 0, go to CHECK.
  - DONE: finished_reading=1, then go to IDLE.
- busy=1 in every state except IDLE.
- Once playback starts, read_checkList is ignored until the block returns to IDLE. Only rst aborts playback.
- list_pop is never asserted when list_empty=1, and never for more than one cycle per entry.
- Outputs are Moore-type, decoded from state and registers. The exception is list_pop, which is decoded from the CHECK state combined with list_empty.

## Timing
- Reset values: pos_x=0, pos_y=0, move_count=0, move_valid=0, list_pop=0, busy=0, finished_reading=0, state=IDLE.
- Non-empty list, with read_checkList sampled high at edge 0:
  - CHECK/list_pop occurs in cycle 1.
  - STEP occurs in cycle 2.
  - move_valid is first high in cycle 3.
- Empty list: finished_reading is high in cycle 2. The block is back in IDLE in cycle 3.
- Per-entry period with move_ready tied high is 3 + HOLD cycles (CHECK, STEP, OUT, then HOLD cycles).
- Backpressure: move_valid stays high and pos_x/pos_y stay stable for as long as move_ready=0. No entry is popped during a stall.
- read_checkList still high in the cycle after DONE restarts playback: positions clear and the list is re-checked. The controller drops read_checkList in response to finished_reading, so this does not occur in normal use.
- rst asserted in any state forces reset values on the next edge. An entry already popped is lost.

## Structure
- Shared package maze_pkg holds:
  - direction constants DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN
  - the player state encoding
- These constants are shared with the solver controller and datapath.
- One sub-module, maze_step_timer: a loadable down-counter of width clog2(HOLD) with load, en and zero outputs. It provides the dwell in HOLD.

## Test plan
- Empty list, read_checkList pulse → no list_pop, no move_valid, finished_reading high in cycle 2, move_count=0.
- List {01,01,11,11,10}, move_ready=1, HOLD=4 → positions (1,0),(2,0),(2,1),(2,2),(1,2), one every 7 cycles, move_count=5, then finished_reading.
- Same list with move_ready low for 10 cycles on the 2nd move → pos (2,0) held stable with move_valid high for 11 cycles, list_pop not asserted during the stall.
- Single entry 00 from (0,0) → pos_y wraps to 15, pos_x=0.
- rst asserted during HOLD after the 2nd move → all outputs return to reset values on the next edge, and no finished_reading pulse occurs.
- read_checkList toggled during playback → ignored, and the move sequence is identical to the undisturbed run.
